// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save resolver (early-termination macro: CSA_RESOLVER_EARLY_EN).
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package csa_pkg;

   // Resolver control states: wait for a pair, resolve chunk by chunk, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } csa_res_state_t;

   // Number of CHUNK-bit slices covering the W+2-bit extended operands.
   function automatic int csa_num_chunks(input int w, input int chunk);
      return (w + 2) / chunk;
   endfunction

   // Width of a chunk index able to hold 0..n-1 (at least one bit).
   function automatic int csa_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// CHUNK-bit ripple-carry adder built from fulladder cells.
// Latency: combinational.
// Backpressure: n/a.
module csa_chunk_add #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   // c[i] is the carry into bit i; c[CHUNK] leaves the chunk.
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fulladder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// Latency: combinational.
// Backpressure: n/a.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair to binary, s_in + (c_in << 1), CHUNK bits per cycle LSB first (optional early exit: CSA_RESOLVER_EARLY_EN).
// Latency: result valid N+1 cycles after input handshake (N = (W+2)/CHUNK); fewer with early exit when upper bits are all zero.
// Backpressure: one pair in flight; in_ready low from acceptance until the cycle after out_valid && out_ready.
module csa_resolver #(
   parameter int W     = 8,
   parameter int CHUNK = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] s_in,
   input  logic [W-1:0] c_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W+1:0] res
);

   import csa_pkg::*;

   // (W+2) must be a multiple of CHUNK; the chunk walk assumes whole slices.
   localparam int WR = W + 2;
   localparam int N  = csa_num_chunks(W, CHUNK);
   localparam int KW = csa_idx_width(N);

   csa_res_state_t state_q, state_d;
   logic [WR-1:0]  a_q, a_d;
   logic [WR-1:0]  b_q, b_d;
   logic [WR-1:0]  res_q, res_d;
   logic           carry_q, carry_d;
   logic [KW-1:0]  k_q, k_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] sum_chunk;
   logic             chunk_cout;
   logic             last_chunk;

   assign a_chunk    = a_q[k_q*CHUNK +: CHUNK];
   assign b_chunk    = b_q[k_q*CHUNK +: CHUNK];
   assign last_chunk = (k_q == KW'(N - 1));

   csa_chunk_add #(
      .CHUNK (CHUNK)
   ) u_chunk_add (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q),
      .s    (sum_chunk),
      .cout (chunk_cout)
   );

`ifdef CSA_RESOLVER_EARLY_EN
   // Nothing left to add from chunk k upward: the remaining result bits are already zero.
   logic early_done;
   assign early_done = (carry_q == 1'b0)
                    && ((a_q >> (k_q*CHUNK)) == '0)
                    && ((b_q >> (k_q*CHUNK)) == '0);
`endif

   // Next-state and datapath update: accept in IDLE, one chunk per BUSY cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = {2'b00, s_in};
               b_d     = {1'b0, c_in, 1'b0};
               res_d   = '0;
               carry_d = 1'b0;
               k_d     = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            res_d[k_q*CHUNK +: CHUNK] = sum_chunk;
            carry_d = chunk_cout;
            k_d     = k_q + 1'b1;
            if (last_chunk) begin
               // The final carry-out is always zero because the sum fits in WR bits.
               k_d     = '0;
               state_d = DONE;
            end
`ifdef CSA_RESOLVER_EARLY_EN
            if (early_done) begin
               res_d   = res_q;
               carry_d = carry_q;
               k_d     = '0;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand, carry, index and result registers; reset overrides any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         k_q     <= k_d;
      end
   end

   // Handshake outputs decode state only; in_ready is also masked while reset is held.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign res       = res_q;

endmodule

// File: tb/tb_csa_resolver.sv
module tb_csa_resolver;

   localparam int W     = 8;
   localparam int CHUNK = 2;
   localparam int N     = (W + 2) / CHUNK;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] s_in;
   logic [W-1:0] c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W+1:0] res;

   int n_chk;
   int n_err;
   int cyc;
   bit cmp_en;

   csa_resolver #(.W(W), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s_in      (s_in),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycles from acceptance to first out_valid, derived from the arithmetic:
   // with early exit, the first chunk k where no carry enters and no operand bit
   // at or above k*CHUNK is set ends the job, and DONE follows one cycle later.
   function automatic int model_lat(input logic [W-1:0] s, input logic [W-1:0] c);
`ifdef CSA_RESOLVER_EARLY_EN
      int a;
      int b;
      int sh;
      int cin;
      a = int'(s);
      b = int'(c) * 2;
      for (int k = 0; k < N; k++) begin
         sh  = k * CHUNK;
         cin = ((a % (1 << sh)) + (b % (1 << sh))) >> sh;
         if (cin == 0 && (a >> sh) == 0 && (b >> sh) == 0) return k + 2;
      end
`endif
      return N + 1;
   endfunction

   // Transaction-level model: one job pending, result and ready-time computed at acceptance.
   bit           m_pending;
   int           m_acc;
   int           m_lat;
   logic [W+1:0] m_res;

   function automatic bit m_valid();
      return m_pending && (cyc >= m_acc + m_lat);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_pending <= 1'b0;
      end else if (!m_pending) begin
         if (in_valid) begin
            m_pending <= 1'b1;
            m_acc     <= cyc;
            m_lat     <= model_lat(s_in, c_in);
            m_res     <= {2'b00, s_in} + {1'b0, c_in, 1'b0};
         end
      end else if (m_valid() && out_ready) begin
         m_pending <= 1'b0;
      end
   end

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", 32'(in_ready), 32'(!m_pending && !rst));
         chk("out_valid", 32'(out_valid), 32'(m_valid()));
         if (m_valid()) chk("res_model", 32'(res), 32'(m_res));
      end
   end

   // Drive a pair and wait for acceptance; t is the handshake cycle.
   task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, output int t);
      s_in     = s;
      c_in     = c;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !in_ready; i++) begin
         @(posedge clk); #2;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      t = cyc;
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int t, output int lat);
      for (int i = 0; i < 40 && !out_valid; i++) begin
         @(posedge clk); #2;
      end
      if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
      lat = cyc - t;
   endtask

   task automatic run(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                      input logic [W+1:0] exp_res, input int exp_lat);
      int t;
      int lat;
      send(s, c, t);
      wait_valid(t, lat);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_res"}, 32'(res), 32'(exp_res));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1;
      int t2;
      int lat1;
      int lat2;
      int lat_03;
      int lat_00;
      int lat_01;
`ifdef CSA_RESOLVER_EARLY_EN
      lat_03 = 3;
      lat_00 = 2;
      lat_01 = 3;
`else
      lat_03 = 6;
      lat_00 = 6;
      lat_01 = 6;
`endif
      n_chk     = 0;
      n_err     = 0;
      cmp_en    = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      s_in      = '0;
      c_in      = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_res", 32'(res), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'h1);
      cmp_en = 1'b1;
      @(posedge clk); #2;

      // Single transactions with the consumer always ready.
      out_ready = 1'b1;
      run("ff_ff", 8'hFF, 8'hFF, 10'h2FD, 6);
      run("03_00", 8'h03, 8'h00, 10'h003, lat_03);
      run("00_00", 8'h00, 8'h00, 10'h000, lat_00);

      // Back-to-back pairs.
      send(8'h55, 8'hAA, t1);
      wait_valid(t1, lat1);
      chk("b2b1_res", 32'(res), 32'h1A9);
      send(8'h80, 8'h01, t2);
      chk("b2b_period", 32'(t2 - t1), 32'(N + 2));
      wait_valid(t2, lat2);
      chk("b2b2_res", 32'(res), 32'h082);
      chk("b2b2_lat", 32'(lat2), 32'd6);

      // Consumer stalls for four cycles while a stray pair is offered.
      @(posedge clk); #2;
      out_ready = 1'b0;
      send(8'h55, 8'hAA, t1);
      wait_valid(t1, lat1);
      chk("hold_lat", 32'(lat1), 32'd6);
      chk("hold_res0", 32'(res), 32'h1A9);
      for (int i = 0; i < 4; i++) begin
         in_valid = (i == 1);
         s_in     = 8'h12;
         c_in     = 8'h34;
         @(posedge clk); #2;
         chk("hold_res", 32'(res), 32'h1A9);
         chk("hold_out_valid", 32'(out_valid), 32'h1);
         chk("hold_in_ready", 32'(in_ready), 32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
      chk("post_hold_out_valid", 32'(out_valid), 32'h0);
      chk("post_hold_in_ready", 32'(in_ready), 32'h1);

      // Reset in the third BUSY cycle abandons the job.
      out_ready = 1'b1;
      send(8'hFF, 8'hFF, t1);
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort_res", 32'(res), 32'h0);
      chk("abort_out_valid", 32'(out_valid), 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #2;
      run("01_01", 8'h01, 8'h01, 10'h003, lat_01);

      repeat (3) @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Multi-cycle carry-propagate resolver for carry-save (sum/carry) vector pairs. It accepts one redundant pair per transaction over a valid/ready handshake. It adds the sum vector to the carry vector shifted left by one, processing `CHUNK` bits per cycle from LSB to MSB, and returns the binary result over a second valid/ready handshake. It sits directly behind the carry-save adder stage and turns its redundant output into a conventional binary value.

## Interface
Parameters:
- `W`, default 8: width of each input vector.
- `CHUNK`, default 2: bits resolved per cycle. `(W+2) % CHUNK == 0` is required.

Ports:
- `clk` in, 1: the only clock; all logic is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: the input pair is valid.
- `in_ready` out, 1: the block can accept a pair.
- `s_in` in, W: carry-save sum vector, weight 2^i.
- `c_in` in, W: carry-save carry vector, weight 2^(i+1).
- `out_valid` out, 1: `res` is valid.
- `out_ready` in, 1: the consumer accepts `res`.
- `res` out, W+2: the result, `s_in + (c_in << 1)`.

## Operation
- Operands are extended internally to `W+2` bits:
  - A = `{2'b0, s_in}`
  - B = `{1'b0, c_in, 1'b0}`
  - N = (W+2)/CHUNK chunks.
  - The result always fits in W+2 bits, so there is no carry-out or overflow.
- The FSM has three states:
  - IDLE: `in_ready` = 1. On `in_valid && in_ready`, latch A and B, clear the result register and the carry register, set chunk index k = 0, and go to BUSY.
  - BUSY: each cycle, add chunk k of A, chunk k of B and the carry register. Write the sum to `res[k*CHUNK +: CHUNK]`, update the carry register and increment k. After chunk N-1, go to DONE.
  - DONE: `out_valid` = 1 and `res` is held stable. On `out_ready`, go to IDLE.
- In BUSY and DONE, `in_ready` = 0 and `in_valid` is ignored. No new pair is accepted in the cycle that DONE→IDLE happens.
- The carry register's value after chunk N-1 is always 0. It is discarded.
- Reset values: state IDLE, `res` = 0, `out_valid` = 0, carry = 0, k = 0. `in_ready` = 0 while `rst` is high.
- Reset during BUSY or DONE abandons the transaction. The next cycle is IDLE with all outputs at their reset values.
- Reset has priority over every handshake in the same cycle.

## Timing
- The input handshake completes in cycle T.
- BUSY occupies cycles T+1 through T+N.
- `out_valid` is first high in cycle T+N+1. With the defaults (N = 5), that is T+6.
- `out_valid` and `res` stay constant until `out_ready` is sampled high. `out_valid` drops the next cycle.
- `in_ready` rises in the cycle after the output handshake.
- Minimum transaction period is N+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- Macro `CSA_RESOLVER_EARLY_EN` controls early termination.
- Defined: in a BUSY cycle at chunk k, if carry == 0 and `A[W+1:k*CHUNK]` == 0 and `B[W+1:k*CHUNK]` == 0, go to DONE at that edge with no further writes. The remaining `res` bits stay 0.
- Undefined: BUSY always lasts exactly N cycles.
- The final `res` value is identical in both builds.

## Structure
- Package `csa_pkg` holds:
  - the state typedef `csa_res_state_t` {IDLE, BUSY, DONE};
  - a function computing N from W and CHUNK.
- Sub-module `csa_chunk_add`: a CHUNK-bit ripple adder with cin/cout, built from the existing `fulladder` cell.
- Top level holds the FSM, the operand registers, the chunk index and the result register.

## Test plan
- s=8'hFF, c=8'hFF → `res` = 10'h2FD; `out_valid` first high at T+6 in both builds.
- s=8'h03, c=8'h00 → `res` = 10'h003; `out_valid` at T+6 without EN, at T+3 with `CSA_RESOLVER_EARLY_EN`.
- s=0, c=0 → `res` = 0; `out_valid` at T+2 with EN, at T+6 without.
- s=8'h55, c=8'hAA, hold `out_ready` = 0 for 4 cycles after `out_valid`, pulse `in_valid` meanwhile → `res` = 10'h1A9 stable throughout, `in_ready` = 0, the extra input is ignored.
- Back-to-back: 8'h55/8'hAA then 8'h80/8'h01, `out_ready` tied high → `res` = 10'h1A9, then 10'h082; second acceptance no earlier than T+N+2.
- Assert `rst` in the 3rd BUSY cycle of s=8'hFF, c=8'hFF → next cycle `res` = 0, `out_valid` = 0, state IDLE; a following 8'h01/8'h01 resolves to 10'h003.
